// File: rtl/nbit_1x2_demux_reg_pkg.sv
// Shared constants for the registered 1-to-2 demux.
// Optional per-channel transfer counters are enabled with DEMUX_COUNT_EN.
package nbit_1x2_demux_reg_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int N_DEFAULT  = 32;
  localparam int CW_DEFAULT = 8;

  // A one-entry slot can take a word when it is empty or emptying this cycle.
  function automatic logic slot_can_load(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/nbit_1x2_demux_reg_slot.sv
// One-entry holding register with valid/ready output handshake.
// A load in the same cycle as a drain replaces the word without a bubble.
module one_entry_slot #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  logic         r_valid;
  logic [N-1:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
    end else if (r_valid && out_ready) begin
      // data is left as-is after a drain; only valid is meaningful
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule

// File: rtl/nbit_1x2_demux_reg.sv
// Registered N-bit 1-to-2 demux: steers one valid/ready stream to channel A or B.
// Define DEMUX_COUNT_EN to add wrapping per-channel accept counters cnt_a/cnt_b.
module nbit_1x2_demux_reg
  import nbit_1x2_demux_reg_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_sel,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [N-1:0]  a_data,
  output logic          b_valid,
  input  logic          b_ready,
  output logic [N-1:0]  b_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
`endif
);

  if (CW < 1) begin : g_cw_check
    $error("CW must be at least 1");
  end

  logic w_ready_a;
  logic w_ready_b;
  logic w_load_a;
  logic w_load_b;

  assign w_ready_a = slot_can_load(a_valid, a_ready);
  assign w_ready_b = slot_can_load(b_valid, b_ready);

  // in_ready looks only at the selected channel, so a stalled channel never
  // blocks producers aimed at the other one.
  assign in_ready = (in_sel == SEL_B) ? w_ready_b : w_ready_a;

  assign w_load_a = in_valid && w_ready_a && (in_sel == SEL_A);
  assign w_load_b = in_valid && w_ready_b && (in_sel == SEL_B);

  one_entry_slot #(.N(N)) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load_a),
    .load_data (in_data),
    .out_valid (a_valid),
    .out_ready (a_ready),
    .out_data  (a_data)
  );

  one_entry_slot #(.N(N)) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load_b),
    .load_data (in_data),
    .out_valid (b_valid),
    .out_ready (b_ready),
    .out_data  (b_data)
  );

`ifdef DEMUX_COUNT_EN
  logic [CW-1:0] r_cnt_a;
  logic [CW-1:0] r_cnt_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_load_a) r_cnt_a <= r_cnt_a + 1'b1;
      if (w_load_b) r_cnt_b <= r_cnt_b + 1'b1;
    end
  end

  assign cnt_a = r_cnt_a;
  assign cnt_b = r_cnt_b;
`endif

endmodule

// File: tb/tb_nbit_1x2_demux_reg.sv
// Self-checking bench for nbit_1x2_demux_reg: directed table, corner sequences,
// and random traffic against a queue-based model. Counter checks under DEMUX_COUNT_EN.
module tb_nbit_1x2_demux_reg;
  import nbit_1x2_demux_reg_pkg::*;

  localparam int N  = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_sel;
  logic          a_valid;
  logic          a_ready;
  logic [N-1:0]  a_data;
  logic          b_valid;
  logic          b_ready;
  logic [N-1:0]  b_data;
`ifdef DEMUX_COUNT_EN
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
`endif

  nbit_1x2_demux_reg #(.N(N), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data)
`ifdef DEMUX_COUNT_EN
    ,
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [N-1:0] d;
    logic         sel;
    logic         ar;
    logic         br;
    logic         e_ir;
    logic         e_av;
    logic [N-1:0] e_ad;
    logic         e_bv;
    logic [N-1:0] e_bd;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: each channel is a queue of capacity one.
  logic [N-1:0] qa[$];
  logic [N-1:0] qb[$];
  int unsigned  m_cnt_a = 0;
  int unsigned  m_cnt_b = 0;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    if (in_sel === SEL_B) return (qb.size() == 0) || b_ready;
    return (qa.size() == 0) || a_ready;
  endfunction

  function automatic void m_clear();
    qa.delete();
    qb.delete();
    m_cnt_a = 0;
    m_cnt_b = 0;
  endfunction

  function automatic void m_edge();
    logic acc;
    logic s;
    acc = in_valid && m_ready();
    s   = in_sel;
    if (qa.size() != 0 && a_ready) void'(qa.pop_front());
    if (qb.size() != 0 && b_ready) void'(qb.pop_front());
    if (acc) begin
      if (s) begin qb.push_back(in_data); m_cnt_b++; end
      else   begin qa.push_back(in_data); m_cnt_a++; end
    end
  endfunction

  task automatic m_check_outputs();
    chk("a_valid", {31'b0, a_valid}, {31'b0, qa.size() != 0});
    chk("b_valid", {31'b0, b_valid}, {31'b0, qb.size() != 0});
    if (qa.size() != 0) chk("a_data", a_data, qa[0]);
    if (qb.size() != 0) chk("b_data", b_data, qb[0]);
`ifdef DEMUX_COUNT_EN
    chk("cnt_a", {24'b0, cnt_a}, m_cnt_a % 256);
    chk("cnt_b", {24'b0, cnt_b}, m_cnt_b % 256);
`endif
  endtask

  // Called just after a falling edge: drive, check in_ready, clock, check outputs.
  task automatic do_cycle(input vec_t v, input bit use_exp);
    in_valid = v.iv;
    in_data  = v.d;
    in_sel   = v.sel;
    a_ready  = v.ar;
    b_ready  = v.br;
    #1;
    if (!$isunknown(in_sel)) chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready()});
    if (use_exp) chk("tbl_in_ready", {31'b0, in_ready}, {31'b0, v.e_ir});
    @(posedge clk);
    m_edge();
    @(negedge clk);
    #1;
    m_check_outputs();
    if (use_exp) begin
      chk("tbl_a_valid", {31'b0, a_valid}, {31'b0, v.e_av});
      chk("tbl_b_valid", {31'b0, b_valid}, {31'b0, v.e_bv});
      if (v.e_av) chk("tbl_a_data", a_data, v.e_ad);
      if (v.e_bv) chk("tbl_b_data", b_data, v.e_bd);
    end
  endtask

  function automatic vec_t mk(logic iv, logic [N-1:0] d, logic sel, logic ar, logic br,
                              logic e_ir, logic e_av, logic [N-1:0] e_ad,
                              logic e_bv, logic [N-1:0] e_bd);
    vec_t v;
    v.iv = iv; v.d = d; v.sel = sel; v.ar = ar; v.br = br;
    v.e_ir = e_ir; v.e_av = e_av; v.e_ad = e_ad; v.e_bv = e_bv; v.e_bd = e_bd;
    return v;
  endfunction

  task automatic pulse_reset();
    #2;
    rst = 1'b0;
    #1;
    m_clear();
    chk("rst_a_valid", {31'b0, a_valid}, 32'd0);
    chk("rst_a_data", a_data, 32'd0);
    chk("rst_b_valid", {31'b0, b_valid}, 32'd0);
    chk("rst_b_data", b_data, 32'd0);
    in_sel = SEL_A;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    vec_t v;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_sel   = SEL_A;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    m_check_outputs();
    rst = 1'b1;

    // Reset mid-stream with A holding a stalled word
    do_cycle(mk(1, 32'hDEADBEEF, SEL_A, 0, 0, 1, 1, 32'hDEADBEEF, 0, 0), 1);
    pulse_reset();

    // Basic routing
    tbl.push_back(mk(1, 32'h11111111, SEL_A, 1, 1, 1, 1, 32'h11111111, 0, 0));
    tbl.push_back(mk(1, 32'h22222222, SEL_B, 1, 1, 1, 0, 0, 1, 32'h22222222));
    tbl.push_back(mk(0, 32'h0,        SEL_A, 1, 1, 1, 0, 0, 0, 0));
    // Backpressure on A does not block B
    tbl.push_back(mk(1, 32'hA0, SEL_A, 0, 1, 1, 1, 32'hA0, 0, 0));
    tbl.push_back(mk(1, 32'hA1, SEL_A, 0, 1, 0, 1, 32'hA0, 0, 0));
    tbl.push_back(mk(1, 32'hB0, SEL_B, 0, 0, 1, 1, 32'hA0, 1, 32'hB0));
    tbl.push_back(mk(1, 32'hA1, SEL_A, 1, 0, 1, 1, 32'hA1, 1, 32'hB0));
    tbl.push_back(mk(0, 32'h0,  SEL_A, 1, 1, 1, 0, 0, 0, 0));
    // Full throughput on A
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, i, SEL_A, 1, 0, 1, 1, i, 0, 0));
    tbl.push_back(mk(0, 32'h0, SEL_A, 1, 0, 1, 0, 0, 0, 0));
    // Simultaneous drain and load on B, then stall blocks only B producers
    tbl.push_back(mk(1, 32'h5, SEL_B, 1, 0, 1, 0, 0, 1, 32'h5));
    tbl.push_back(mk(1, 32'h6, SEL_B, 1, 1, 1, 0, 0, 1, 32'h6));
    tbl.push_back(mk(1, 32'h7, SEL_B, 1, 0, 0, 0, 0, 1, 32'h6));
    tbl.push_back(mk(0, 32'h0, SEL_A, 1, 0, 1, 0, 0, 1, 32'h6));
    tbl.push_back(mk(0, 32'h0, SEL_A, 1, 1, 1, 0, 0, 0, 0));
    foreach (tbl[i]) do_cycle(tbl[i], 1);

    // Unknown select while idle must not disturb state
    do_cycle(mk(1, 32'hC0, SEL_A, 0, 0, 1, 1, 32'hC0, 0, 0), 1);
    for (int i = 0; i < 4; i++) begin
      v = mk(0, $urandom, 1'bx, 0, 0, 0, 0, 0, 0, 0);
      do_cycle(v, 0);
    end
    chk("x_sel_a_data", a_data, 32'hC0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      v = mk($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
             $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, 0, 0, 0, 0, 0);
      do_cycle(v, 0);
    end

`ifdef DEMUX_COUNT_EN
    pulse_reset();
    for (int i = 0; i < 257; i++) do_cycle(mk(1, i, SEL_A, 1, 1, 0, 0, 0, 0, 0), 0);
    for (int i = 0; i < 3; i++)   do_cycle(mk(1, i, SEL_B, 1, 1, 0, 0, 0, 0, 0), 0);
    chk("cnt_a_wrap", {24'b0, cnt_a}, 32'd1);
    chk("cnt_b_final", {24'b0, cnt_b}, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
